id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 114 +++++++++++
 tb/tb_id_ex_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with load-use hazard
// detection, downstream stall hold, flush and an optional write-back bypass.
//
// Build option: define WB_BYPASS_EN to forward the same-cycle register-file
// write (wb_*) into the operands. The forwarding happens on load, and again
// while the stage is held by ex_stall. With the macro undefined, the operands
// come only from id_rdata1/id_rdata2.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_memwrite,
    input  logic [3:0]  id_opcode,
    input  logic [3:0]  id_src1,
    input  logic [3:0]  id_src2,
    input  logic [3:0]  id_dst,
    input  logic [15:0] id_imm,
    input  logic [15:0] id_rdata1,
    input  logic [15:0] id_rdata2,
    input  logic        wb_regwrite,
    input  logic [3:0]  wb_dst,
    input  logic [15:0] wb_data,
    input  logic        ex_stall,
    input  logic        flush,
    output logic        ex_valid,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic [3:0]  ex_opcode,
    output logic [3:0]  ex_src1,
    output logic [3:0]  ex_src2,
    output logic [3:0]  ex_dst,
    output logic [15:0] ex_imm,
    output logic [15:0] ex_op1,
    output logic [15:0] ex_op2,
    output logic        id_stall
);

`ifdef WB_BYPASS_EN
    localparam bit BypassEn = 1'b1;
`else
    localparam bit BypassEn = 1'b0;
`endif

    logic        hazard;
    logic [15:0] loadOp1;
    logic [15:0] loadOp2;
    logic [15:0] holdOp1;
    logic [15:0] holdOp2;

    // Load-use detection: a load sitting in execute whose destination is read
    // by the decode instruction. Both sources are compared and R0 is not special.
    always_comb begin
        hazard = ex_valid & ex_memread & ex_regwrite & id_valid &
                 ((id_src1 == ex_dst) | (id_src2 == ex_dst));
        id_stall = ex_stall | hazard;
    end

    // Operand selection. The register file returns pre-write data, so the
    // write port is forwarded on load. A held instruction also picks up any
    // write to its sources; if src1 equals src2, both operands take the write.
    always_comb begin
        loadOp1 = id_rdata1;
        loadOp2 = id_rdata2;
        holdOp1 = ex_op1;
        holdOp2 = ex_op2;
        if (BypassEn && wb_regwrite && (wb_dst == id_src1)) loadOp1 = wb_data;
        if (BypassEn && wb_regwrite && (wb_dst == id_src2)) loadOp2 = wb_data;
        if (BypassEn && ex_valid && wb_regwrite && (wb_dst == ex_src1)) holdOp1 = wb_data;
        if (BypassEn && ex_valid && wb_regwrite && (wb_dst == ex_src2)) holdOp2 = wb_data;
    end

    // Pipeline register. Priority: reset, flush, downstream stall, load-use bubble, load.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_opcode   <= 4'h0;
            ex_src1     <= 4'h0;
            ex_src2     <= 4'h0;
            ex_dst      <= 4'h0;
            ex_imm      <= 16'h0000;
            ex_op1      <= 16'h0000;
            ex_op2      <= 16'h0000;
        end else if (flush || (!ex_stall && hazard)) begin
            // Flush kills the instruction. A bubble moves the load out of
            // execute, so the hazard clears on the next edge.
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
        end else if (ex_stall) begin
            ex_op1 <= holdOp1;
            ex_op2 <= holdOp2;
        end else begin
            ex_valid    <= id_valid;
            ex_regwrite <= id_valid & id_regwrite;
            ex_memread  <= id_valid & id_memread;
            ex_memwrite <= id_valid & id_memwrite;
            ex_opcode   <= id_opcode;
            ex_src1     <= id_src1;
            ex_src2     <= id_src2;
            ex_dst      <= id_dst;
            ex_imm      <= id_imm;
            ex_op1      <= loadOp1;
            ex_op2      <= loadOp2;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed cases plus randomized stimulus, checked against a
// behavioural model of the execute-stage bundle.
// Build option: WB_BYPASS_EN selects the forwarding expectations.
module tb_id_ex_stage;

`ifdef WB_BYPASS_EN
    localparam bit BypassEn = 1'b1;
`else
    localparam bit BypassEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_regwrite, id_memread, id_memwrite;
    logic [3:0]  id_opcode, id_src1, id_src2, id_dst;
    logic [15:0] id_imm, id_rdata1, id_rdata2;
    logic        wb_regwrite;
    logic [3:0]  wb_dst;
    logic [15:0] wb_data;
    logic        ex_stall, flush;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite;
    logic [3:0]  ex_opcode, ex_src1, ex_src2, ex_dst;
    logic [15:0] ex_imm, ex_op1, ex_op2;
    logic        id_stall;

    typedef struct packed {
        logic        valid, regwrite, memread, memwrite;
        logic [3:0]  opcode, src1, src2, dst;
        logic [15:0] imm, op1, op2;
    } exT;

    exT model;
    bit checkEn = 1'b0;
    int nChecks = 0;
    int nFails = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_opcode(id_opcode), .id_src1(id_src1),
        .id_src2(id_src2), .id_dst(id_dst), .id_imm(id_imm), .id_rdata1(id_rdata1),
        .id_rdata2(id_rdata2), .wb_regwrite(wb_regwrite), .wb_dst(wb_dst),
        .wb_data(wb_data), .ex_stall(ex_stall), .flush(flush),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_opcode(ex_opcode), .ex_src1(ex_src1),
        .ex_src2(ex_src2), .ex_dst(ex_dst), .ex_imm(ex_imm), .ex_op1(ex_op1),
        .ex_op2(ex_op2), .id_stall(id_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // A load in execute blocks any decode instruction that reads its destination.
    function automatic bit modelHazard(exT e);
        return e.valid && e.memread && e.regwrite && id_valid &&
               (id_src1 == e.dst || id_src2 == e.dst);
    endfunction

    // Reference model: advance the bundle on each edge, then compare all outputs.
    always @(posedge clk) begin
        exT nxt;
        nxt = model;
        if (rst) begin
            nxt = '0;
        end else if (flush) begin
            {nxt.valid, nxt.regwrite, nxt.memread, nxt.memwrite} = 4'b0000;
        end else if (ex_stall) begin
            if (BypassEn && model.valid && wb_regwrite && wb_dst == model.src1) nxt.op1 = wb_data;
            if (BypassEn && model.valid && wb_regwrite && wb_dst == model.src2) nxt.op2 = wb_data;
        end else if (modelHazard(model)) begin
            {nxt.valid, nxt.regwrite, nxt.memread, nxt.memwrite} = 4'b0000;
        end else begin
            nxt.valid    = id_valid;
            nxt.regwrite = id_valid && id_regwrite;
            nxt.memread  = id_valid && id_memread;
            nxt.memwrite = id_valid && id_memwrite;
            nxt.opcode   = id_opcode;
            nxt.src1     = id_src1;
            nxt.src2     = id_src2;
            nxt.dst      = id_dst;
            nxt.imm      = id_imm;
            nxt.op1 = (BypassEn && wb_regwrite && wb_dst == id_src1) ? wb_data : id_rdata1;
            nxt.op2 = (BypassEn && wb_regwrite && wb_dst == id_src2) ? wb_data : id_rdata2;
        end
        model = nxt;
        #1;
        if (checkEn) begin
            chk("m_valid", 16'(ex_valid), 16'(model.valid));
            chk("m_regwrite", 16'(ex_regwrite), 16'(model.regwrite));
            chk("m_memread", 16'(ex_memread), 16'(model.memread));
            chk("m_memwrite", 16'(ex_memwrite), 16'(model.memwrite));
            chk("m_opcode", 16'(ex_opcode), 16'(model.opcode));
            chk("m_src1", 16'(ex_src1), 16'(model.src1));
            chk("m_src2", 16'(ex_src2), 16'(model.src2));
            chk("m_dst", 16'(ex_dst), 16'(model.dst));
            chk("m_imm", ex_imm, model.imm);
            chk("m_op1", ex_op1, model.op1);
            chk("m_op2", ex_op2, model.op2);
            chk("m_id_stall", 16'(id_stall), 16'(ex_stall || modelHazard(model)));
        end
    end

    task automatic clearInputs();
        rst = 0; id_valid = 0; id_regwrite = 0; id_memread = 0; id_memwrite = 0;
        id_opcode = 0; id_src1 = 0; id_src2 = 0; id_dst = 0;
        id_imm = 0; id_rdata1 = 0; id_rdata2 = 0;
        wb_regwrite = 0; wb_dst = 0; wb_data = 0; ex_stall = 0; flush = 0;
    endtask

    initial begin
        // Reset with every input high.
        clearInputs();
        rst = 1; id_valid = 1; id_regwrite = 1; id_memread = 1; id_memwrite = 1;
        id_opcode = 4'hF; id_src1 = 4'hF; id_src2 = 4'hF; id_dst = 4'hF;
        id_imm = 16'hFFFF; id_rdata1 = 16'hFFFF; id_rdata2 = 16'hFFFF;
        wb_regwrite = 1; wb_dst = 4'hF; wb_data = 16'hFFFF; ex_stall = 1; flush = 1;
        @(posedge clk); #1;
        checkEn = 1'b1;
        chk("rst_valid", 16'(ex_valid), 16'h0);
        chk("rst_ctrl", 16'({ex_regwrite, ex_memread, ex_memwrite}), 16'h0);
        chk("rst_fields", 16'({ex_opcode, ex_src1, ex_src2, ex_dst}), 16'h0);
        chk("rst_ops", ex_imm | ex_op1 | ex_op2, 16'h0);
        @(negedge clk); ex_stall = 0; #1;
        chk("rst_id_stall", 16'(id_stall), 16'h0);

        // Plain load.
        @(negedge clk); clearInputs();
        id_valid = 1; id_src1 = 3; id_rdata1 = 16'h1234; id_imm = 16'h0042;
        @(posedge clk); #1;
        chk("load_op1", ex_op1, 16'h1234);
        chk("load_imm", ex_imm, 16'h0042);
        chk("load_valid", 16'(ex_valid), 16'h1);

        // Load-use: one bubble, then capture.
        @(negedge clk); clearInputs();
        id_valid = 1; id_memread = 1; id_regwrite = 1; id_dst = 5;
        @(posedge clk);
        @(negedge clk); clearInputs();
        id_valid = 1; id_src1 = 1; id_src2 = 5; id_opcode = 4'h9; #1;
        chk("lu_stall", 16'(id_stall), 16'h1);
        @(posedge clk); #1;
        chk("lu_bubble", 16'(ex_valid), 16'h0);
        chk("lu_stall_clr", 16'(id_stall), 16'h0);
        @(posedge clk); #1;
        chk("lu_capture", 16'({ex_valid, ex_opcode, ex_src2}), 16'h195);

        // Write-back bypass on load.
        @(negedge clk); clearInputs();
        id_valid = 1; id_regwrite = 1; id_memwrite = 1; id_src1 = 7; id_rdata1 = 16'h0000;
        wb_regwrite = 1; wb_dst = 7; wb_data = 16'hBEEF;
        @(posedge clk); #1;
        chk("bypass_op1", ex_op1, BypassEn ? 16'hBEEF : 16'h0000);

        // Flush beats stall.
        @(negedge clk); clearInputs();
        flush = 1; ex_stall = 1; #1;
        chk("flush_id_stall_pre", 16'(id_stall), 16'h1);
        @(posedge clk); #1;
        chk("flush_valid", 16'(ex_valid), 16'h0);
        chk("flush_ctrl", 16'({ex_regwrite, ex_memread, ex_memwrite}), 16'h0);
        chk("flush_id_stall", 16'(id_stall), 16'(ex_stall));

        // Refresh of a held operand.
        @(negedge clk); clearInputs();
        id_valid = 1; id_src2 = 4; id_rdata2 = 16'h1111; id_imm = 16'h0077;
        @(posedge clk);
        @(negedge clk); clearInputs();
        ex_stall = 1; wb_regwrite = 1; wb_dst = 4; wb_data = 16'h00FF;
        id_valid = 1; id_src2 = 9; id_imm = 16'hAAAA;
        @(posedge clk); #1;
        chk("hold_op2", ex_op2, BypassEn ? 16'h00FF : 16'h1111);
        chk("hold_fields", 16'({ex_valid, ex_src2}), 16'h14);
        chk("hold_imm", ex_imm, 16'h0077);

        // Randomized traffic over a small register range to hit hazards often.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst         = ($urandom_range(0, 99) < 2);
            flush       = ($urandom_range(0, 99) < 8);
            ex_stall    = ($urandom_range(0, 99) < 20);
            id_valid    = ($urandom_range(0, 99) < 80);
            id_regwrite = 1'($urandom);
            id_memread  = ($urandom_range(0, 99) < 50);
            id_memwrite = 1'($urandom);
            id_opcode   = 4'($urandom);
            id_src1     = 4'($urandom_range(0, 3));
            id_src2     = 4'($urandom_range(0, 3));
            id_dst      = 4'($urandom_range(0, 3));
            id_imm      = 16'($urandom);
            id_rdata1   = 16'($urandom);
            id_rdata2   = 16'($urandom);
            wb_regwrite = 1'($urandom);
            wb_dst      = 4'($urandom_range(0, 3));
            wb_data     = 16'($urandom);
        end
        @(posedge clk); #2;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
